execute_stage_pipelined: RTL and testbench

//  Parametrised successor to the MIPS EX stage: ALU + ALU control, RegDst mux and branch-target adder,
//  now with a registered EX/MEM output, valid/ready/stall/flush handshake and an iterative multu unit

---
 rtl/execute_stage_pipelined_pkg.sv | 52 +++++
 rtl/execute_stage_pipelined_if.sv | 38 +++
 rtl/ex_seq_multiplier.sv | 59 +++++
 rtl/execute_stage_pipelined.sv | 156 +++++++++++++++
 tb/tb_execute_stage_pipelined.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pipelined_pkg.sv
// rtl/execute_stage_pipelined_pkg.sv - opcode/funct encodings, ALU ops and FSM states for the EX stage
package execute_stage_pipelined_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
        ALU_SLT, ALU_MFHI, ALU_MFLO, ALU_MULTU
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic alu_op_e alu_ctrl(input logic [1:0] aluop, input logic [5:0] funct);
        case (aluop)
            ALUOP_ADD: return ALU_ADD;
            ALUOP_SUB: return ALU_SUB;
            ALUOP_OR:  return ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:   return ALU_ADD;
                    FN_SUB:   return ALU_SUB;
                    FN_AND:   return ALU_AND;
                    FN_OR:    return ALU_OR;
                    FN_NOR:   return ALU_NOR;
                    FN_SLT:   return ALU_SLT;
                    FN_MFHI:  return ALU_MFHI;
                    FN_MFLO:  return ALU_MFLO;
                    FN_MULTU: return ALU_MULTU;
                    default:  return ALU_NONE;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_pipelined_if.sv
// rtl/execute_stage_pipelined_if.sv - ID/EX input, MEM handshake and EX/MEM output bundle
interface execute_stage_pipelined_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  stall;
    logic                  flush;
    logic                  aluSrc;
    logic [1:0]            ALUOp;
    logic                  regDst;
    logic [DATA_W-1:0]     pcPlusFour;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [DATA_W-1:0]     signExtend;
    logic [REG_ADDR_W-1:0] regDst1;
    logic [REG_ADDR_W-1:0] regDst2;
    logic                  out_valid;
    logic [DATA_W-1:0]     addResult;
    logic                  zero;
    logic [DATA_W-1:0]     aluResult;
    logic [DATA_W-1:0]     reg2Out;
    logic [REG_ADDR_W-1:0] muxRegDstOut;
    logic                  busy;

    modport master (
        output in_valid, stall, flush, aluSrc, ALUOp, regDst, pcPlusFour,
               reg1, reg2, signExtend, regDst1, regDst2,
        input  in_ready, out_valid, addResult, zero, aluResult, reg2Out, muxRegDstOut, busy
    );

    modport slave (
        input  in_valid, stall, flush, aluSrc, ALUOp, regDst, pcPlusFour,
               reg1, reg2, signExtend, regDst1, regDst2,
        output in_ready, out_valid, addResult, zero, aluResult, reg2Out, muxRegDstOut, busy
    );
endinterface

// File: rtl/ex_seq_multiplier.sv
// rtl/ex_seq_multiplier.sv - unsigned radix-2 shift-add multiplier, one partial product per cycle
module ex_seq_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic [DATA_W:0]     sum;

    // acc holds {partial high half, remaining multiplier bits}; add then shift right by one
    assign sum      = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum, acc_q[DATA_W-1:1]};
    // the last step is presented combinationally so the stage finishes in exactly DATA_W cycles
    assign done     = run_q && (cnt_q == LAST);
    assign product  = acc_step;

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (start) begin
            mcand_d = a;
            acc_d   = {{DATA_W{1'b0}}, b};
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d = acc_step;
            if (done) run_d = 1'b0;
            else      cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end
endmodule

// File: rtl/execute_stage_pipelined.sv
// rtl/execute_stage_pipelined.sv - pipelined EX stage: ALU, RegDst mux, branch adder, multu with HI/LO
module execute_stage_pipelined
    import execute_stage_pipelined_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    execute_stage_pipelined_if.slave    ex
);
    state_e                state_q, state_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]     alu_res_q, alu_res_d, add_q, add_d, reg2_q, reg2_d;
    logic                  zero_q, zero_d, out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d, mul_dst_q, mul_dst_d;
    logic [DATA_W-1:0]     mul_reg2_q, mul_reg2_d, mul_add_q, mul_add_d;

    alu_op_e               op;
    logic [DATA_W-1:0]     alu_b, alu_y, add_y, mul_lo;
    logic [REG_ADDR_W-1:0] dst_sel;
    logic                  accept, is_multu, mul_start, mul_done, hilo_we, mul_out;
    logic [2*DATA_W-1:0]   mul_prod;

    assign ex.in_ready = !reset && (state_q == ST_IDLE) && !ex.stall;
    assign accept      = ex.in_valid && ex.in_ready && !ex.flush;
    assign op          = alu_ctrl(ex.ALUOp, ex.signExtend[5:0]);
    assign is_multu    = (op == ALU_MULTU);
    assign mul_start   = accept && is_multu;
    assign alu_b       = ex.aluSrc ? ex.signExtend : ex.reg2;
    assign add_y       = ex.pcPlusFour + (ex.signExtend << 2);
    assign dst_sel     = ex.regDst ? ex.regDst2 : ex.regDst1;

    ex_seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ex.reg1),
        .b       (alu_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        alu_y = '0;
        case (op)
            ALU_ADD:  alu_y = ex.reg1 + alu_b;
            ALU_SUB:  alu_y = ex.reg1 - alu_b;
            ALU_AND:  alu_y = ex.reg1 & alu_b;
            ALU_OR:   alu_y = ex.reg1 | alu_b;
            ALU_NOR:  alu_y = ~(ex.reg1 | alu_b);
            ALU_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(ex.reg1) < $signed(alu_b))};
            ALU_MFHI: alu_y = hi_q;
            ALU_MFLO: alu_y = lo_q;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (ex.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_start) state_d = ST_MUL;
                ST_MUL:  if (mul_done) state_d = ex.stall ? ST_HOLD : ST_IDLE;
                ST_HOLD: if (!ex.stall) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // HI/LO land on completion even under stall; only the output load waits for the MEM stage
    assign hilo_we = (state_q == ST_MUL) && mul_done && !ex.flush;
    assign mul_out = !ex.flush && !ex.stall &&
                     (((state_q == ST_MUL) && mul_done) || (state_q == ST_HOLD));
    assign mul_lo  = (state_q == ST_HOLD) ? lo_q : mul_prod[DATA_W-1:0];

    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        alu_res_d   = alu_res_q;
        add_d       = add_q;
        reg2_d      = reg2_q;
        zero_d      = zero_q;
        dst_d       = dst_q;
        out_valid_d = out_valid_q;
        mul_dst_d   = mul_dst_q;
        mul_reg2_d  = mul_reg2_q;
        mul_add_d   = mul_add_q;
        if (hilo_we) {hi_d, lo_d} = mul_prod;
        if (mul_start) begin
            mul_dst_d  = dst_sel;
            mul_reg2_d = ex.reg2;
            mul_add_d  = add_y;
        end
        if (ex.flush) begin
            out_valid_d = 1'b0;
        end else if (!ex.stall) begin
            out_valid_d = 1'b0;
            if (mul_out) begin
                out_valid_d = 1'b1;
                alu_res_d   = mul_lo;
                zero_d      = (mul_lo == '0);
                add_d       = mul_add_q;
                reg2_d      = mul_reg2_q;
                dst_d       = mul_dst_q;
            end else if (accept && !is_multu) begin
                out_valid_d = 1'b1;
                alu_res_d   = alu_y;
                zero_d      = (alu_y == '0);
                add_d       = add_y;
                reg2_d      = ex.reg2;
                dst_d       = dst_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            alu_res_q   <= '0;
            add_q       <= '0;
            reg2_q      <= '0;
            zero_q      <= 1'b0;
            dst_q       <= '0;
            out_valid_q <= 1'b0;
            mul_dst_q   <= '0;
            mul_reg2_q  <= '0;
            mul_add_q   <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            alu_res_q   <= alu_res_d;
            add_q       <= add_d;
            reg2_q      <= reg2_d;
            zero_q      <= zero_d;
            dst_q       <= dst_d;
            out_valid_q <= out_valid_d;
            mul_dst_q   <= mul_dst_d;
            mul_reg2_q  <= mul_reg2_d;
            mul_add_q   <= mul_add_d;
        end
    end

    assign ex.out_valid    = out_valid_q;
    assign ex.aluResult    = alu_res_q;
    assign ex.zero         = zero_q;
    assign ex.addResult    = add_q;
    assign ex.reg2Out      = reg2_q;
    assign ex.muxRegDstOut = dst_q;
    assign ex.busy         = (state_q == ST_MUL);
endmodule

// File: tb/tb_execute_stage_pipelined.sv
// tb/tb_execute_stage_pipelined.sv - directed self-checking bench for execute_stage_pipelined
module tb_execute_stage_pipelined;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n;

    always #5 clk = ~clk;

    execute_stage_pipelined_if #(.DATA_W(32), .REG_ADDR_W(5)) ex_if ();

    execute_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (ex_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_if.in_valid   = 1'b0;
        ex_if.stall      = 1'b0;
        ex_if.flush      = 1'b0;
        ex_if.aluSrc     = 1'b0;
        ex_if.ALUOp      = 2'b00;
        ex_if.regDst     = 1'b0;
        ex_if.pcPlusFour = '0;
        ex_if.reg1       = '0;
        ex_if.reg2       = '0;
        ex_if.signExtend = '0;
        ex_if.regDst1    = '0;
        ex_if.regDst2    = '0;
    endtask

    task automatic issue(input logic [1:0] op, input logic src, input logic rdst,
                         input logic [31:0] se, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc, input logic [4:0] d1, input logic [4:0] d2);
        ex_if.in_valid   = 1'b1;
        ex_if.ALUOp      = op;
        ex_if.aluSrc     = src;
        ex_if.regDst     = rdst;
        ex_if.signExtend = se;
        ex_if.reg1       = r1;
        ex_if.reg2       = r2;
        ex_if.pcPlusFour = pc;
        ex_if.regDst1    = d1;
        ex_if.regDst2    = d2;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        tick();
        chk("rst_in_ready", 64'(ex_if.in_ready), 64'd0);
        chk("rst_out_valid", 64'(ex_if.out_valid), 64'd0);
        chk("rst_alu", 64'(ex_if.aluResult), 64'd0);
        chk("rst_busy", 64'(ex_if.busy), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ex_if.in_ready), 64'd1);

        // R-type add
        issue(2'b10, 1'b0, 1'b1, 32'h20, 32'd7, 32'd3, 32'd0, 5'd4, 5'd9);
        tick();
        idle_in();
        chk("add_valid", 64'(ex_if.out_valid), 64'd1);
        chk("add_res", 64'(ex_if.aluResult), 64'd10);
        chk("add_zero", 64'(ex_if.zero), 64'd0);
        chk("add_dst", 64'(ex_if.muxRegDstOut), 64'd9);
        chk("add_br", 64'(ex_if.addResult), 64'h80);
        chk("add_reg2out", 64'(ex_if.reg2Out), 64'd3);
        tick();
        chk("bubble_valid", 64'(ex_if.out_valid), 64'd0);

        // sub giving zero, branch target
        issue(2'b01, 1'b0, 1'b0, 32'd25, 32'd7, 32'd7, 32'd32, 5'd5, 5'd6);
        tick();
        chk("sub_res", 64'(ex_if.aluResult), 64'd0);
        chk("sub_zero", 64'(ex_if.zero), 64'd1);
        chk("sub_br", 64'(ex_if.addResult), 64'd132);
        chk("sub_dst", 64'(ex_if.muxRegDstOut), 64'd5);
        // back-to-back: or immediate, add immediate -1
        issue(2'b11, 1'b1, 1'b0, 32'h0F, 32'hF0, 32'd0, 32'd0, 5'd1, 5'd2);
        tick();
        chk("ori_res", 64'(ex_if.aluResult), 64'hFF);
        chk("ori_valid", 64'(ex_if.out_valid), 64'd1);
        issue(2'b00, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd100, 32'd0, 32'd0, 5'd1, 5'd2);
        tick();
        chk("addi_wrap", 64'(ex_if.aluResult), 64'd99);

        // slt signed, swapped operands, and/nor, unknown funct
        issue(2'b10, 1'b0, 1'b1, 32'h2A, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd3, 5'd17);
        tick();
        chk("slt_neg", 64'(ex_if.aluResult), 64'd1);
        chk("slt_dst", 64'(ex_if.muxRegDstOut), 64'd17);
        issue(2'b10, 1'b0, 1'b1, 32'h2A, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd3, 5'd17);
        tick();
        chk("slt_swap", 64'(ex_if.aluResult), 64'd0);
        chk("slt_swap_zero", 64'(ex_if.zero), 64'd1);
        issue(2'b10, 1'b0, 1'b0, 32'h24, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 5'd3, 5'd17);
        tick();
        chk("and_res", 64'(ex_if.aluResult), 64'h0F000F00);
        issue(2'b10, 1'b0, 1'b0, 32'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 5'd3, 5'd17);
        tick();
        chk("nor_res", 64'(ex_if.aluResult), 64'h00000F0F);
        issue(2'b10, 1'b0, 1'b0, 32'h3F, 32'd5, 32'd6, 32'd0, 5'd3, 5'd17);
        tick();
        chk("unk_res", 64'(ex_if.aluResult), 64'd0);
        chk("unk_valid", 64'(ex_if.out_valid), 64'd1);

        // stall holds, stall+flush clears valid
        issue(2'b10, 1'b0, 1'b0, 32'h20, 32'd1, 32'd1, 32'd0, 5'd3, 5'd17);
        ex_if.stall = 1'b1;
        tick();
        chk("stall_ready", 64'(ex_if.in_ready), 64'd0);
        chk("stall_valid", 64'(ex_if.out_valid), 64'd1);
        chk("stall_res", 64'(ex_if.aluResult), 64'd0);
        ex_if.flush = 1'b1;
        tick();
        chk("stall_flush_valid", 64'(ex_if.out_valid), 64'd0);
        idle_in();

        // multu 0xFFFFFFFF * 2 then mfhi/mflo
        issue(2'b10, 1'b0, 1'b1, 32'h19, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd3, 5'd8);
        tick();
        idle_in();
        chk("mul_busy", 64'(ex_if.busy), 64'd1);
        chk("mul_start_valid", 64'(ex_if.out_valid), 64'd0);
        n = 0;
        while (ex_if.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("mul_latency", 64'(n), 64'd32);
        chk("mul_valid", 64'(ex_if.out_valid), 64'd1);
        chk("mul_lo", 64'(ex_if.aluResult), 64'hFFFFFFFE);
        chk("mul_dst", 64'(ex_if.muxRegDstOut), 64'd8);
        chk("mul_busy_done", 64'(ex_if.busy), 64'd0);
        issue(2'b10, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        chk("mfhi", 64'(ex_if.aluResult), 64'd1);
        issue(2'b10, 1'b0, 1'b0, 32'h12, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        chk("mflo", 64'(ex_if.aluResult), 64'hFFFFFFFE);
        idle_in();

        // stall across multu completion -> HOLD
        issue(2'b10, 1'b0, 1'b1, 32'h19, 32'd5, 32'd6, 32'd0, 5'd3, 5'd12);
        tick();
        idle_in();
        repeat (31) tick();
        chk("hold_pre_busy", 64'(ex_if.busy), 64'd1);
        ex_if.stall = 1'b1;
        tick();
        chk("hold_valid", 64'(ex_if.out_valid), 64'd0);
        chk("hold_res", 64'(ex_if.aluResult), 64'hFFFFFFFE);
        chk("hold_busy", 64'(ex_if.busy), 64'd0);
        chk("hold_ready", 64'(ex_if.in_ready), 64'd0);
        tick();
        chk("hold2_valid", 64'(ex_if.out_valid), 64'd0);
        ex_if.stall = 1'b0;
        tick();
        chk("release_valid", 64'(ex_if.out_valid), 64'd1);
        chk("release_res", 64'(ex_if.aluResult), 64'd30);
        chk("release_dst", 64'(ex_if.muxRegDstOut), 64'd12);
        chk("release_ready", 64'(ex_if.in_ready), 64'd1);

        // flush mid-multu with HI/LO freshly reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_res", 64'(ex_if.aluResult), 64'd0);
        issue(2'b10, 1'b0, 1'b0, 32'h19, 32'd7, 32'd3, 32'd0, 5'd3, 5'd12);
        tick();
        idle_in();
        repeat (10) tick();
        ex_if.flush = 1'b1;
        tick();
        ex_if.flush = 1'b0;
        chk("flush_valid", 64'(ex_if.out_valid), 64'd0);
        chk("flush_busy", 64'(ex_if.busy), 64'd0);
        chk("flush_ready", 64'(ex_if.in_ready), 64'd1);
        repeat (25) tick();
        chk("flush_late_valid", 64'(ex_if.out_valid), 64'd0);
        issue(2'b10, 1'b0, 1'b0, 32'h12, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        chk("flush_mflo", 64'(ex_if.aluResult), 64'd0);
        chk("flush_mflo_valid", 64'(ex_if.out_valid), 64'd1);
        issue(2'b10, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        chk("flush_mfhi", 64'(ex_if.aluResult), 64'd0);

        // reset mid-multu
        issue(2'b00, 1'b0, 1'b1, 32'd1, 32'd5, 32'd6, 32'd4, 5'd1, 5'd7);
        tick();
        chk("pre_rst_res", 64'(ex_if.aluResult), 64'd11);
        chk("pre_rst_br", 64'(ex_if.addResult), 64'd8);
        issue(2'b10, 1'b0, 1'b1, 32'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd3, 5'd7);
        tick();
        idle_in();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("midrst_valid", 64'(ex_if.out_valid), 64'd0);
        chk("midrst_res", 64'(ex_if.aluResult), 64'd0);
        chk("midrst_br", 64'(ex_if.addResult), 64'd0);
        chk("midrst_reg2", 64'(ex_if.reg2Out), 64'd0);
        chk("midrst_dst", 64'(ex_if.muxRegDstOut), 64'd0);
        chk("midrst_busy", 64'(ex_if.busy), 64'd0);
        chk("midrst_ready", 64'(ex_if.in_ready), 64'd0);
        reset = 1'b0;
        issue(2'b10, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        idle_in();
        chk("midrst_mfhi", 64'(ex_if.aluResult), 64'd0);
        chk("midrst_mfhi_valid", 64'(ex_if.out_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
